// File: rtl/tag_table_writer_pkg.sv
// Shared defaults and FSM encoding for the tag table writer.
package tag_table_writer_pkg;

  localparam int unsigned TagSizeDefault    = 64;
  localparam int unsigned LogVecSizeDefault = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StCommit = 2'd2
  } state_e;

endpackage

// File: rtl/tag_table_writer_find_value_idx.sv
// findValueIdx: combinational lookup of a tag against the valid entries of the tag matrix.
module tag_table_writer_find_value_idx
  import tag_table_writer_pkg::*;
#(
  parameter int unsigned LogVecSize = LogVecSizeDefault,
  parameter int unsigned TagSize    = TagSizeDefault
) (
  input  logic [0:TagSize-1]                           value_i,
  input  logic [0:(1 << LogVecSize)-1][0:TagSize-1]    mat_i,
  input  logic [0:(1 << LogVecSize)-1]                 valid_i,
  output logic                                         hit_o,
  output logic [LogVecSize-1:0]                        idx_o
);

  localparam int unsigned VecSize = 1 << LogVecSize;

  // Lowest matching valid entry; at most one can match since tags are never duplicated.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < VecSize; i++) begin
      if (!hit_o && valid_i[i] && (mat_i[i] == value_i)) begin
        hit_o = 1'b1;
        idx_o = LogVecSize'(i);
      end
    end
  end

endmodule

// File: rtl/tag_table_writer.sv
// Tag table allocation: insert tags over valid/ready, reuse hits, fill free entries,
// otherwise evict a round-robin victim. Owns the tag matrix and valid vector.
module tag_table_writer
  import tag_table_writer_pkg::*;
#(
  parameter int unsigned LOG_VEC_SIZE = LogVecSizeDefault,
  parameter int unsigned TAG_SIZE     = TagSizeDefault
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [0:TAG_SIZE-1]                           req_tag,
  input  logic                                          inv_valid,
  input  logic [0:LOG_VEC_SIZE-1]                       inv_idx,
  output logic                                          resp_valid,
  output logic [0:LOG_VEC_SIZE-1]                       resp_idx,
  output logic                                          resp_hit,
  output logic                                          resp_evicted,
  output logic [0:TAG_SIZE-1]                           resp_evict_tag,
  output logic [0:(1 << LOG_VEC_SIZE)-1]                valid,
  output logic [0:(1 << LOG_VEC_SIZE)-1][0:TAG_SIZE-1]  tagMat
);

  localparam int unsigned VecSize = 1 << LOG_VEC_SIZE;
  typedef logic [LOG_VEC_SIZE-1:0] idx_t;

  state_e state_q, state_d;
  logic [0:TAG_SIZE-1] tag_q;

  logic lookup_hit;
  idx_t lookup_idx;
  logic free_found;
  idx_t free_idx;

  // Lookup results frozen at the end of SEARCH
  logic hit_q, free_found_q;
  idx_t match_idx_q, free_idx_q;

  idx_t victim_q, victim_d;
  logic [0:VecSize-1] valid_q, valid_d;
  logic [0:VecSize-1][0:TAG_SIZE-1] tag_mat_q;

  logic hit_live, write_en, evict_sel;
  idx_t write_idx;

  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic               resp_evicted_q, resp_evicted_d;
  idx_t               resp_idx_q, resp_idx_d;
  logic [0:TAG_SIZE-1] resp_evict_tag_q, resp_evict_tag_d;

  tag_table_writer_find_value_idx #(
    .LogVecSize (LOG_VEC_SIZE),
    .TagSize    (TAG_SIZE)
  ) u_find_value_idx (
    .value_i (tag_q),
    .mat_i   (tag_mat_q),
    .valid_i (valid_q),
    .hit_o   (lookup_hit),
    .idx_o   (lookup_idx)
  );

  // Lowest-index free entry
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < VecSize; i++) begin
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
  end

  // COMMIT decision; a hit whose entry was invalidated during SEARCH falls back to a miss
  always_comb begin
    hit_live  = hit_q && valid_q[match_idx_q];
    write_idx = free_found_q ? free_idx_q : victim_q;
    write_en  = (state_q == StCommit) && !hit_live;
    evict_sel = write_en && !free_found_q;
  end

  // FSM next state and handshake
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StSearch;
      end
      StSearch: state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next valid vector, victim pointer and registered response
  always_comb begin
    valid_d = valid_q;
    if (inv_valid) valid_d[inv_idx] = 1'b0;
    // Commit write overrides a same-cycle invalidation of the same entry
    if (write_en) valid_d[write_idx] = 1'b1;

    victim_d = victim_q;
    if (evict_sel) victim_d = victim_q + idx_t'(1);

    resp_valid_d     = 1'b0;
    resp_hit_d       = 1'b0;
    resp_idx_d       = '0;
    resp_evicted_d   = 1'b0;
    resp_evict_tag_d = '0;
    if (state_q == StCommit) begin
      resp_valid_d   = 1'b1;
      resp_hit_d     = hit_live;
      resp_idx_d     = hit_live ? match_idx_q : write_idx;
      resp_evicted_d = evict_sel && valid_q[victim_q];
      if (resp_evicted_d) resp_evict_tag_d = tag_mat_q[victim_q];
    end
  end

  // Control state, captured request and SEARCH results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      tag_q            <= '0;
      hit_q            <= 1'b0;
      match_idx_q      <= '0;
      free_found_q     <= 1'b0;
      free_idx_q       <= '0;
      victim_q         <= '0;
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_idx_q       <= '0;
      resp_evicted_q   <= 1'b0;
      resp_evict_tag_q <= '0;
    end else begin
      state_q          <= state_d;
      victim_q         <= victim_d;
      resp_valid_q     <= resp_valid_d;
      resp_hit_q       <= resp_hit_d;
      resp_idx_q       <= resp_idx_d;
      resp_evicted_q   <= resp_evicted_d;
      resp_evict_tag_q <= resp_evict_tag_d;
      if (state_q == StIdle && req_valid) tag_q <= req_tag;
      if (state_q == StSearch) begin
        hit_q        <= lookup_hit;
        match_idx_q  <= lookup_idx;
        free_found_q <= free_found;
        free_idx_q   <= free_idx;
      end
    end
  end

  // Table storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      tag_mat_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (write_en) tag_mat_q[write_idx] <= tag_q;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_idx       = resp_idx_q;
  assign resp_hit       = resp_hit_q;
  assign resp_evicted   = resp_evicted_q;
  assign resp_evict_tag = resp_evict_tag_q;
  assign valid          = valid_q;
  assign tagMat         = tag_mat_q;

endmodule
